// File: rtl/cond_flags_reader.sv
// Evaluates the ARM condition field of each instruction against the NZCV flags
// and hands the execute/skip decision downstream, stalling while flags are written.
module cond_flags_reader #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] flags_do,
  input  logic              flags_wr_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_cond,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_execute,
  output logic [TAG_W-1:0]  out_tag,
  output logic [CNT_W-1:0]  exec_cnt,
  output logic [CNT_W-1:0]  skip_cnt
);

  typedef enum logic [1:0] {EMPTY, WAIT, FULL} state_t;

  state_t             state_q, state_d;
  logic               out_execute_q, out_execute_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;
  logic [3:0]         cond_q, cond_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [CNT_W-1:0]   exec_cnt_q, exec_cnt_d;
  logic [CNT_W-1:0]   skip_cnt_q, skip_cnt_d;

  logic [3:0]         nzcv;
  logic               accept;
  logic               handoff;
  logic               in_ready_c;
  logic               flags_unused;

  assign nzcv         = flags_do[DATA_W-1 -: 4];
  assign flags_unused = ^flags_do[DATA_W-5:0];

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    logic r;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cond)
      4'b0000: r = z;
      4'b0001: r = !z;
      4'b0010: r = c;
      4'b0011: r = !c;
      4'b0100: r = n;
      4'b0101: r = !n;
      4'b0110: r = v;
      4'b0111: r = !v;
      4'b1000: r = c && !z;
      4'b1001: r = !c || z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = !z && (n == v);
      4'b1101: r = z || (n != v);
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d       = state_q;
    out_execute_d = out_execute_q;
    out_tag_d     = out_tag_q;
    cond_d        = cond_q;
    tag_d         = tag_q;
    exec_cnt_d    = exec_cnt_q;
    skip_cnt_d    = skip_cnt_q;

    in_ready_c = (state_q == EMPTY) || ((state_q == FULL) && out_ready);
    accept     = in_valid && in_ready_c;
    handoff    = (state_q == FULL) && out_ready;

    if (handoff) begin
      if (out_execute_q) begin
        if (exec_cnt_q != '1) exec_cnt_d = exec_cnt_q + CNT_W'(1);
      end else begin
        if (skip_cnt_q != '1) skip_cnt_d = skip_cnt_q + CNT_W'(1);
      end
    end

    // A pending instruction resolves only once the flags register has settled.
    if (state_q == WAIT) begin
      if (!flags_wr_en) begin
        out_execute_d = cond_pass(cond_q, nzcv);
        out_tag_d     = tag_q;
        state_d       = FULL;
      end
    end else if (accept) begin
      if (flags_wr_en) begin
        cond_d  = in_cond;
        tag_d   = in_tag;
        state_d = WAIT;
      end else begin
        out_execute_d = cond_pass(in_cond, nzcv);
        out_tag_d     = in_tag;
        state_d       = FULL;
      end
    end else if (handoff) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= EMPTY;
      out_execute_q <= 1'b0;
      out_tag_q     <= '0;
      cond_q        <= '0;
      tag_q         <= '0;
      exec_cnt_q    <= '0;
      skip_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      out_execute_q <= out_execute_d;
      out_tag_q     <= out_tag_d;
      cond_q        <= cond_d;
      tag_q         <= tag_d;
      exec_cnt_q    <= exec_cnt_d;
      skip_cnt_q    <= skip_cnt_d;
    end
  end

  assign in_ready    = in_ready_c;
  assign out_valid   = (state_q == FULL);
  assign out_execute = out_execute_q;
  assign out_tag     = out_tag_q;
  assign exec_cnt    = exec_cnt_q;
  assign skip_cnt    = skip_cnt_q;

endmodule

// File: tb/tb_cond_flags_reader.sv
// Self-checking bench for cond_flags_reader: directed sequences, a full
// condition sweep table, and randomized traffic against a transaction model.
module tb_cond_flags_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] flags_do;
  logic        flags_wr_en;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_cond;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic        out_execute;
  logic [7:0]  out_tag;
  logic [15:0] exec_cnt;
  logic [15:0] skip_cnt;

  logic        in_ready4;
  logic        out_valid4;
  logic        out_execute4;
  logic [7:0]  out_tag4;
  logic [3:0]  exec_cnt4;
  logic [3:0]  skip_cnt4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cond_flags_reader #(.DATA_W(32), .TAG_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flags_do(flags_do), .flags_wr_en(flags_wr_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_cond(in_cond), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_execute(out_execute),
    .out_tag(out_tag), .exec_cnt(exec_cnt), .skip_cnt(skip_cnt)
  );

  cond_flags_reader #(.DATA_W(32), .TAG_W(8), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .flags_do(flags_do), .flags_wr_en(flags_wr_en),
    .in_valid(in_valid), .in_ready(in_ready4), .in_cond(in_cond), .in_tag(in_tag),
    .out_valid(out_valid4), .out_ready(out_ready), .out_execute(out_execute4),
    .out_tag(out_tag4), .exec_cnt(exec_cnt4), .skip_cnt(skip_cnt4)
  );

  // Bit k of entry c is the expected outcome of condition c for NZCV == k.
  localparam logic [15:0] MASKS [16] = '{
    16'hF0F0, 16'h0F0F, 16'hCCCC, 16'h3333,
    16'hFF00, 16'h00FF, 16'hAAAA, 16'h5555,
    16'h0C0C, 16'hF3F3, 16'hAA55, 16'h55AA,
    16'h0A05, 16'hF5FA, 16'hFFFF, 16'h0000
  };

  function automatic logic expect_pass(input logic [3:0] cond, input logic [3:0] f);
    logic [15:0] m;
    m = MASKS[cond];
    return m[f];
  endfunction

  typedef struct {
    logic [3:0] cond;
    logic [3:0] nzcv;
    logic       exp;
  } vec_t;

  vec_t vecs [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flags_wr_en = 1'b0;
    in_valid    = 1'b0;
    in_cond     = 4'h0;
    in_tag      = 8'h00;
    out_ready   = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
  endtask

  // Transaction-level model state for the random phase.
  bit      m_has, m_pend, m_exec;
  bit [7:0] m_tag, m_ptag;
  bit [3:0] m_pcond;
  int      m_ec, m_sc;

  initial begin
    int unsigned ec_before, sc_before;
    bit exp_ready;

    for (int c = 0; c < 16; c++)
      for (int f = 0; f < 16; f++) begin
        vecs[c*16+f].cond = 4'(c);
        vecs[c*16+f].nzcv = 4'(f);
        vecs[c*16+f].exp  = MASKS[c][f];
      end

    flags_do = 32'h0;
    #2;
    do_reset();

    // Reset then idle
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_execute", {31'b0, out_execute}, 32'd0);
    check("rst_out_tag", {24'b0, out_tag}, 32'd0);
    check("rst_exec_cnt", {16'b0, exec_cnt}, 32'd0);
    check("rst_skip_cnt", {16'b0, skip_cnt}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // EQ then NE with Z set, back to back
    flags_do = 32'h4000_0000;
    in_valid = 1'b1; in_cond = 4'h0; in_tag = 8'h11;
    tick();
    check("eq_valid", {31'b0, out_valid}, 32'd1);
    check("eq_exec", {31'b0, out_execute}, 32'd1);
    check("eq_tag", {24'b0, out_tag}, 32'h11);
    in_cond = 4'h1; in_tag = 8'h12;
    tick();
    check("ne_valid", {31'b0, out_valid}, 32'd1);
    check("ne_exec", {31'b0, out_execute}, 32'd0);
    check("ne_tag", {24'b0, out_tag}, 32'h12);
    in_valid = 1'b0;
    tick();
    check("eqne_idle_valid", {31'b0, out_valid}, 32'd0);
    check("eqne_exec_cnt", {16'b0, exec_cnt}, 32'd1);
    check("eqne_skip_cnt", {16'b0, skip_cnt}, 32'd1);

    // Interlock: flags written in the accept cycle
    flags_do = 32'h0;
    flags_wr_en = 1'b1;
    in_valid = 1'b1; in_cond = 4'h0; in_tag = 8'h21;
    #1;
    check("ilk_accept_ready", {31'b0, in_ready}, 32'd1);
    tick();
    flags_do = 32'h4000_0000;
    flags_wr_en = 1'b0;
    in_valid = 1'b0;
    #1;
    check("ilk_wait_ready", {31'b0, in_ready}, 32'd0);
    check("ilk_wait_valid", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;
    tick();
    check("ilk_valid", {31'b0, out_valid}, 32'd1);
    check("ilk_exec", {31'b0, out_execute}, 32'd1);
    check("ilk_tag", {24'b0, out_tag}, 32'h21);

    // Backpressure with a new instruction waiting
    ec_before = exec_cnt;
    sc_before = skip_cnt;
    in_valid = 1'b1; in_cond = 4'h1; in_tag = 8'h33;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      tick();
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_exec", {31'b0, out_execute}, 32'd1);
      check("bp_tag", {24'b0, out_tag}, 32'h21);
      check("bp_exec_cnt", {16'b0, exec_cnt}, ec_before);
      check("bp_skip_cnt", {16'b0, skip_cnt}, sc_before);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("bp_new_tag", {24'b0, out_tag}, 32'h33);
    check("bp_new_exec", {31'b0, out_execute}, 32'd0);
    check("bp_exec_cnt_rel", {16'b0, exec_cnt}, ec_before + 1);

    // Reset while FULL and handing off: nothing counted
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rfull_valid", {31'b0, out_valid}, 32'd0);
    check("rfull_tag", {24'b0, out_tag}, 32'd0);
    check("rfull_exec_cnt", {16'b0, exec_cnt}, 32'd0);
    check("rfull_skip_cnt", {16'b0, skip_cnt}, 32'd0);
    tick();
    check("rfull_after_cnt", {16'b0, exec_cnt + skip_cnt}, 32'd0);

    // Full condition sweep, one decision per cycle
    in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      flags_do = {vecs[i].nzcv, 28'h5A5A5A5};
      in_cond  = vecs[i].cond;
      in_tag   = 8'(i);
      tick();
      if (out_valid !== 1'b1 || out_tag !== 8'(i))
        check("sweep_handshake", {23'b0, out_valid, out_tag}, {23'b0, 1'b1, 8'(i)});
      check($sformatf("sweep_c%0h_f%0h", vecs[i].cond, vecs[i].nzcv),
            {31'b0, out_execute}, {31'b0, vecs[i].exp});
    end
    in_valid = 1'b0;
    tick();

    // Saturation: 20 AL instructions
    do_reset();
    in_valid = 1'b1; in_cond = 4'hE;
    for (int i = 0; i < 20; i++) begin
      in_tag = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("sat4_exec_cnt", {28'b0, exec_cnt4}, 32'd15);
    check("sat4_skip_cnt", {28'b0, skip_cnt4}, 32'd0);
    check("sat4_idle", {30'b0, out_valid4, in_ready4}, 32'd1);
    check("sat4_last", {23'b0, out_execute4, out_tag4}, {23'b0, 1'b1, 8'd19});
    check("sat16_exec_cnt", {16'b0, exec_cnt}, 32'd20);

    // Randomized traffic against the transaction model
    do_reset();
    m_has = 0; m_pend = 0; m_exec = 0; m_tag = 0; m_ptag = 0; m_pcond = 0;
    m_ec = 0; m_sc = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_cond     = 4'($urandom);
      in_tag      = 8'($urandom);
      out_ready   = ($urandom_range(0, 3) != 0);
      flags_wr_en = ($urandom_range(0, 9) < 3);
      #1;
      exp_ready = (!m_has && !m_pend) || (m_has && out_ready);
      check("rnd_in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
      check("rnd_out_valid", {31'b0, out_valid}, {31'b0, m_has});
      if (m_has)
        check("rnd_decision", {23'b0, out_execute, out_tag}, {23'b0, m_exec, m_tag});
      check("rnd_exec_cnt", {16'b0, exec_cnt}, m_ec);
      check("rnd_skip_cnt", {16'b0, skip_cnt}, m_sc);

      if (m_has && out_ready) begin
        if (m_exec) m_ec = (m_ec < 65535) ? m_ec + 1 : m_ec;
        else        m_sc = (m_sc < 65535) ? m_sc + 1 : m_sc;
        m_has = 0;
      end
      if (m_pend) begin
        if (!flags_wr_en) begin
          m_pend = 0;
          m_has  = 1;
          m_exec = expect_pass(m_pcond, flags_do[31:28]);
          m_tag  = m_ptag;
        end
      end else if (in_valid && exp_ready) begin
        if (flags_wr_en) begin
          m_pend  = 1;
          m_pcond = in_cond;
          m_ptag  = in_tag;
        end else begin
          m_has  = 1;
          m_exec = expect_pass(in_cond, flags_do[31:28]);
          m_tag  = in_tag;
        end
      end

      @(posedge clk);
      if (flags_wr_en) flags_do = $urandom;
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
